// File: rtl/glitch_response_monitor_pkg.sv
// Shared definitions for the glitch response monitor and its UART receiver.
// SYS_CLK_HZ is the board clock also used by the glitch controller.
package glitch_response_monitor_pkg;

    localparam int SYS_CLK_HZ = 25000000;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } mon_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/glitch_response_monitor_uart_rx.sv
// 8N1 UART receiver, LSB first, with a 2-FF input synchronizer.
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to mid start bit, re-check it is still low
// RX_DATA  | sampling 8 data bits every DIV cycles
// RX_STOP  | sampling the stop bit, then pulse valid or framing error
module uart_rx
    import glitch_response_monitor_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] BYTE,
    output logic       BYTE_VALID,
    output logic       FRAMING_ERR
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       byte_n;
    logic             valid_n, ferr_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic             tick;

    // Synchronizer resets low so a line already low at release is not seen as a start edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta     <= 1'b0;
            rx_sync     <= 1'b0;
            rx_prev     <= 1'b0;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            BYTE        <= '0;
            BYTE_VALID  <= 1'b0;
            FRAMING_ERR <= 1'b0;
        end else begin
            rx_meta     <= RX;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            BYTE        <= byte_n;
            BYTE_VALID  <= valid_n;
            FRAMING_ERR <= ferr_n;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        byte_n    = BYTE;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_n = RX_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_sync) begin
                    state_n = RX_IDLE;
                end else begin
                    state_n   = RX_DATA;
                    cnt_n     = FULL_LOAD;
                    bit_idx_n = '0;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shift_n = {rx_sync, shift[7:1]};
                    cnt_n   = FULL_LOAD;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else                 bit_idx_n = bit_idx + 1'b1;
                end
            end
            RX_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        valid_n = 1'b1;
                        byte_n  = shift;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/glitch_response_monitor.sv
// Collects the target's ciphertext frame over UART and reports clean, faulted or no response.
// state   | meaning
// IDLE    | waiting for ARM, received bytes are not compared
// COLLECT | comparing bytes against EXPECT, running the silence timer
// REPORT  | one-cycle DONE with FAULT/TIMEOUT valid
module glitch_response_monitor
    import glitch_response_monitor_pkg::*;
#(
    parameter int CLK_HZ         = SYS_CLK_HZ,
    parameter int BAUD           = 9600,
    parameter int FRAME_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 10
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     RX,
    input  logic                     ARM,
    input  logic [8*FRAME_BYTES-1:0] EXPECT,
    output logic                     BYTE_VALID,
    output logic [7:0]               BYTE,
    output logic                     FRAMING_ERR,
    output logic                     DONE,
    output logic                     FAULT,
    output logic                     TIMEOUT
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int IDX_W = cnt_width(FRAME_BYTES);
    localparam int TMR_W = cnt_width(TIMEOUT_CYCLES);

    mon_state_t       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [TMR_W-1:0] timer, timer_n, timer_inc;
    logic             mismatch, mismatch_n, mismatch_acc;
    logic             fault_n, timeout_n;
    logic [7:0]       exp_byte;
    logic             rx_event, last_slot;

    uart_rx #(.DIV(DIV)) u_uart_rx (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .RX          (RX),
        .BYTE        (BYTE),
        .BYTE_VALID  (BYTE_VALID),
        .FRAMING_ERR (FRAMING_ERR)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            idx      <= '0;
            timer    <= '0;
            mismatch <= 1'b0;
            FAULT    <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            timer    <= timer_n;
            mismatch <= mismatch_n;
            FAULT    <= fault_n;
            TIMEOUT  <= timeout_n;
        end
    end

    always_comb begin
        exp_byte = '0;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (idx == IDX_W'(i)) exp_byte = EXPECT[8*i +: 8];
        end
    end

    assign rx_event     = BYTE_VALID | FRAMING_ERR;
    assign last_slot    = (idx == IDX_W'(FRAME_BYTES - 1));
    assign timer_inc    = timer + 1'b1;
    assign mismatch_acc = mismatch | FRAMING_ERR | (BYTE_VALID & (BYTE != exp_byte));

    // Priority inside COLLECT: ARM, then a byte event, then the silence timer.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        timer_n    = timer;
        mismatch_n = mismatch;
        fault_n    = FAULT;
        timeout_n  = TIMEOUT;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (ARM) state_n = COLLECT;
            end
            COLLECT: begin
                if (ARM) begin
                    state_n = COLLECT;
                end else if (rx_event) begin
                    mismatch_n = mismatch_acc;
                    idx_n      = idx + 1'b1;
                    timer_n    = '0;
                    if (last_slot) begin
                        state_n = REPORT;
                        fault_n = mismatch_acc;
                    end
                end else if (timer_inc == TMR_W'(TIMEOUT_CYCLES)) begin
                    state_n   = REPORT;
                    timeout_n = 1'b1;
                    fault_n   = 1'b0;
                end else begin
                    timer_n = timer_inc;
                end
            end
            REPORT: begin
                DONE    = 1'b1;
                state_n = ARM ? COLLECT : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (ARM) begin
            idx_n      = '0;
            timer_n    = '0;
            mismatch_n = 1'b0;
            fault_n    = 1'b0;
            timeout_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_glitch_response_monitor.sv
// Directed bench for glitch_response_monitor: frame table plus reset, glitch and re-arm sequences.
module tb_glitch_response_monitor;

    localparam int FB  = 16;
    localparam int DIV = 10;
    localparam int TO  = 2000;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          RX;
    logic          ARM;
    logic [8*FB-1:0] EXPECT;
    logic          BYTE_VALID;
    logic [7:0]    BYTE;
    logic          FRAMING_ERR;
    logic          DONE;
    logic          FAULT;
    logic          TIMEOUT;

    glitch_response_monitor #(
        .CLK_HZ(1000000), .BAUD(100000), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RX(RX), .ARM(ARM), .EXPECT(EXPECT),
        .BYTE_VALID(BYTE_VALID), .BYTE(BYTE), .FRAMING_ERR(FRAMING_ERR),
        .DONE(DONE), .FAULT(FAULT), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0, bv_cnt = 0, fe_cnt = 0, done_cnt = 0;
    int   arm_cyc = 0, done_cyc = 0, last_bv_cyc = 0;
    logic done_fault = 1'b0, done_to = 1'b0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (BYTE_VALID) begin
            bv_cnt      <= bv_cnt + 1;
            last_bv_cyc <= cyc;
        end
        if (FRAMING_ERR) fe_cnt <= fe_cnt + 1;
        if (ARM) arm_cyc <= cyc;
        if (DONE) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            done_fault <= FAULT;
            done_to    <= TIMEOUT;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int b = 0; b < 8; b++) begin
            RX = data[b];
            repeat (DIV) @(negedge CLK);
        end
        RX = stop;
        repeat (DIV) @(negedge CLK);
        RX = 1'b1;
        if (stop) last_good = data;
    endtask

    task automatic arm_pulse();
        @(negedge CLK);
        ARM = 1'b1;
        @(negedge CLK);
        ARM = 1'b0;
    endtask

    task automatic wait_done(input int snap, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge CLK);
            if (done_cnt != snap) seen = 1'b1;
        end
    endtask

    task automatic send_frame(input int n, input int bad_idx, input logic [7:0] bad_val);
        for (int i = 0; i < n; i++) begin
            if (i == bad_idx) send_byte(bad_val, 1'b1);
            else              send_byte(8'(i), 1'b1);
        end
    endtask

    typedef struct {
        string      name;
        int         n_bytes;
        int         bad_idx;
        logic [7:0] bad_val;
        logic       exp_fault;
        logic       exp_to;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  sd, sb, sf;
        bit  seen;

        vecs[0] = '{"clean",      16, -1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{"bad_b5",     16,  5, 8'h04, 1'b1, 1'b0};
        vecs[2] = '{"silent",      0, -1, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{"partial3",    3, -1, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{"bad_last",   16, 15, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{"bad_first",  16,  0, 8'h80, 1'b1, 1'b0};

        for (int i = 0; i < FB; i++) EXPECT[8*i +: 8] = 8'(i);
        RX = 1'b1;
        ARM = 1'b0;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_byte_valid", 32'(BYTE_VALID), 0);
        chk("rst_byte", 32'(BYTE), 0);
        chk("rst_framing_err", 32'(FRAMING_ERR), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_fault", 32'(FAULT), 0);
        chk("rst_timeout", 32'(TIMEOUT), 0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            sd = done_cnt;
            sb = bv_cnt;
            arm_pulse();
            send_frame(vecs[v].n_bytes, vecs[v].bad_idx, vecs[v].bad_val);
            wait_done(sd, 3 * TO, seen);
            chk({vecs[v].name, "_done_seen"}, 32'(seen), 1);
            chk({vecs[v].name, "_fault"}, 32'(done_fault), 32'(vecs[v].exp_fault));
            chk({vecs[v].name, "_timeout"}, 32'(done_to), 32'(vecs[v].exp_to));
            chk({vecs[v].name, "_bytes"}, 32'(bv_cnt - sb), 32'(vecs[v].n_bytes));
            if (vecs[v].exp_to && vecs[v].n_bytes == 0)
                chk({vecs[v].name, "_latency"}, 32'(done_cyc - arm_cyc), TO + 1);
            else if (vecs[v].exp_to)
                chk({vecs[v].name, "_latency"}, 32'(done_cyc - last_bv_cyc), TO + 1);
            else
                chk({vecs[v].name, "_latency"}, 32'(done_cyc - last_bv_cyc), 1);
            repeat (20) @(negedge CLK);
            chk({vecs[v].name, "_single_done"}, 32'(done_cnt - sd), 1);
        end
        chk("byte_held", 32'(BYTE), 32'(last_good));

        // 3-cycle low glitch must be rejected as a false start
        sb = bv_cnt;
        sf = fe_cnt;
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        repeat (150) @(negedge CLK);
        chk("glitch_no_byte", 32'(bv_cnt - sb), 0);
        chk("glitch_no_ferr", 32'(fe_cnt - sf), 0);

        // stop bit low consumes slot 0, so the following frame faults
        sd = done_cnt;
        sf = fe_cnt;
        arm_pulse();
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge CLK);
        chk("ferr_pulse", 32'(fe_cnt - sf), 1);
        chk("ferr_byte_kept", 32'(BYTE), 32'(last_good));
        send_frame(16, -1, 8'h00);
        wait_done(sd, 3 * TO, seen);
        chk("ferr_done_seen", 32'(seen), 1);
        chk("ferr_fault", 32'(done_fault), 1);
        chk("ferr_timeout", 32'(done_to), 0);
        repeat (20) @(negedge CLK);

        // reset asserted in the middle of byte 7
        arm_pulse();
        send_frame(7, -1, 8'h00);
        RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        RX = 1'b1;
        repeat (3 * DIV) @(negedge CLK);
        chk("pre_rst_byte", 32'(BYTE), 6);
        RST_N = 1'b0;
        #1;
        chk("midrst_byte", 32'(BYTE), 0);
        chk("midrst_byte_valid", 32'(BYTE_VALID), 0);
        chk("midrst_framing_err", 32'(FRAMING_ERR), 0);
        chk("midrst_done", 32'(DONE), 0);
        chk("midrst_fault", 32'(FAULT), 0);
        chk("midrst_timeout", 32'(TIMEOUT), 0);
        repeat (5) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        sd = done_cnt;
        arm_pulse();
        send_frame(16, -1, 8'h00);
        wait_done(sd, 3 * TO, seen);
        chk("postrst_done_seen", 32'(seen), 1);
        chk("postrst_fault", 32'(done_fault), 0);
        chk("postrst_timeout", 32'(done_to), 0);
        repeat (20) @(negedge CLK);

        // re-ARM after 8 bytes restarts the frame
        sd = done_cnt;
        sb = bv_cnt;
        arm_pulse();
        send_frame(8, -1, 8'h00);
        chk("rearm_no_early_done", 32'(done_cnt - sd), 0);
        arm_pulse();
        send_frame(16, -1, 8'h00);
        wait_done(sd, 3 * TO, seen);
        chk("rearm_done_seen", 32'(seen), 1);
        chk("rearm_done_count", 32'(done_cnt - sd), 1);
        chk("rearm_fault", 32'(done_fault), 0);
        chk("rearm_bytes", 32'(bv_cnt - sb), 24);
        chk("rearm_latency", 32'(done_cyc - last_bv_cyc), 1);

        repeat (10) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
